// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: operands, dispatched micro-ops, CDB writeback
// packets and the AGU scheduler entry.
package uarch_pkg;

  localparam int unsigned TAG_W               = 6;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned AGU_SCHED_DEPTH     = 8;
  localparam int unsigned AGU_SCHED_CDB_PORTS = 2;

  typedef struct packed {
    logic              is_renamed;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    logic             is_valid;
    logic [TAG_W-1:0] dest_tag;
    operand_t         src_0_a;
    operand_t         src_0_b;
  } instruction_t;

  typedef struct packed {
    logic              is_valid;
    logic [TAG_W-1:0]  dest_tag;
    logic [DATA_W-1:0] result;
  } writeback_packet_t;

  typedef struct packed {
    logic         valid;
    instruction_t inst;
  } sched_entry_t;

endpackage

// File: rtl/agu_sched_wakeup.sv
// Operand wakeup: snoops every CDB port and captures the result for a waiting
// operand whose tag matches a valid broadcast.
module agu_sched_wakeup
  import uarch_pkg::*;
#(
  parameter int unsigned CDB_PORTS = AGU_SCHED_CDB_PORTS
) (
  input  operand_t                           operand,
  input  writeback_packet_t [CDB_PORTS-1:0]  cdb,
  output operand_t                           operand_next,
  output logic                               match
);

  always_comb begin
    operand_next = operand;
    match        = 1'b0;
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      if (operand.is_renamed && cdb[p].is_valid && (cdb[p].dest_tag == operand.tag)) begin
        match                   = 1'b1;
        operand_next.is_renamed = 1'b0;
        operand_next.data       = cdb[p].result;
      end
    end
  end

endmodule

// File: rtl/agu_sched.sv
// AGU issue scheduler: collapsing queue of memory micro-ops, CDB wakeup and
// oldest-ready issue. Define AGU_SCHED_BYPASS_EN for same-cycle CDB-to-issue.
module agu_sched
  import uarch_pkg::*;
#(
  parameter int unsigned DEPTH     = AGU_SCHED_DEPTH,
  parameter int unsigned CDB_PORTS = AGU_SCHED_CDB_PORTS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               dispatch_valid,
  input  instruction_t                       dispatch_packet,
  output logic                               dispatch_ready,
  input  writeback_packet_t [CDB_PORTS-1:0]  cdb,
  output instruction_t                       agu_packet,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  sched_entry_t entries [DEPTH];
  sched_entry_t cur     [DEPTH];
  sched_entry_t nxt     [DEPTH];
  operand_t     woke_a  [DEPTH];
  operand_t     woke_b  [DEPTH];
  logic [DEPTH-1:0] match_a, match_b, ready;

  operand_t     disp_woke_a, disp_woke_b;
  logic         disp_match_a, disp_match_b;
  instruction_t disp_inst;

  logic             issue, accept;
  logic [OCC_W-1:0] sel_pos, tail;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    agu_sched_wakeup #(.CDB_PORTS(CDB_PORTS)) u_wake_a (
      .operand(entries[g].inst.src_0_a), .cdb(cdb),
      .operand_next(woke_a[g]), .match(match_a[g]));
    agu_sched_wakeup #(.CDB_PORTS(CDB_PORTS)) u_wake_b (
      .operand(entries[g].inst.src_0_b), .cdb(cdb),
      .operand_next(woke_b[g]), .match(match_b[g]));
  end

  agu_sched_wakeup #(.CDB_PORTS(CDB_PORTS)) u_disp_wake_a (
    .operand(dispatch_packet.src_0_a), .cdb(cdb),
    .operand_next(disp_woke_a), .match(disp_match_a));
  agu_sched_wakeup #(.CDB_PORTS(CDB_PORTS)) u_disp_wake_b (
    .operand(dispatch_packet.src_0_b), .cdb(cdb),
    .operand_next(disp_woke_b), .match(disp_match_b));

  assign dispatch_ready = (occupancy < OCC_W'(DEPTH));
  assign accept         = dispatch_valid && dispatch_ready;
  assign tail           = occupancy - OCC_W'(issue);

  always_comb begin
    disp_inst          = dispatch_packet;
    disp_inst.is_valid = 1'b1;
    disp_inst.src_0_a  = disp_match_a ? disp_woke_a : dispatch_packet.src_0_a;
    disp_inst.src_0_b  = disp_match_b ? disp_woke_b : dispatch_packet.src_0_b;
  end

  // Entries with this cycle's CDB results folded in; this is what gets stored.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cur[i]              = entries[i];
      cur[i].inst.src_0_a = match_a[i] ? woke_a[i] : entries[i].inst.src_0_a;
      cur[i].inst.src_0_b = match_b[i] ? woke_b[i] : entries[i].inst.src_0_b;
    end
  end

  always_comb begin
    ready      = '0;
    issue      = 1'b0;
    sel_pos    = '0;
    agu_packet = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef AGU_SCHED_BYPASS_EN
      ready[i] = cur[i].valid && !cur[i].inst.src_0_a.is_renamed
                 && !cur[i].inst.src_0_b.is_renamed;
`else
      ready[i] = entries[i].valid && !entries[i].inst.src_0_a.is_renamed
                 && !entries[i].inst.src_0_b.is_renamed;
`endif
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ready[i] && !issue) begin
        issue   = 1'b1;
        sel_pos = OCC_W'(i);
`ifdef AGU_SCHED_BYPASS_EN
        agu_packet = cur[i].inst;
`else
        agu_packet = entries[i].inst;
`endif
        agu_packet.is_valid = 1'b1;
      end
    end
    if (flush) begin
      agu_packet = '0;
    end
  end

  // Collapse: entries above the issued slot move down one; the new op lands at
  // the post-collapse tail.
  always_comb begin
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      nxt[i] = (issue && (OCC_W'(i) >= sel_pos)) ? cur[i+1] : cur[i];
    end
    nxt[DEPTH-1] = issue ? '0 : cur[DEPTH-1];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (accept && (OCC_W'(i) == tail)) begin
        nxt[i].valid = 1'b1;
        nxt[i].inst  = disp_inst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries   <= '{default: '0};
      occupancy <= '0;
    end else if (flush) begin
      entries   <= '{default: '0};
      occupancy <= '0;
    end else begin
      entries   <= nxt;
      occupancy <= occupancy + OCC_W'(accept) - OCC_W'(issue);
    end
  end

endmodule

// File: tb/tb_agu_sched.sv
// Directed bench for agu_sched: vector table for single-cycle behaviour plus
// hand sequences for full queue, collapse, flush and asynchronous reset.
module tb_agu_sched;
  import uarch_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned CDB_PORTS = 2;
`ifdef AGU_SCHED_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic                              clk, rst, flush, dispatch_valid, dispatch_ready;
  instruction_t                      dispatch_packet, agu_packet;
  writeback_packet_t [CDB_PORTS-1:0] cdb;
  logic [$clog2(DEPTH+1)-1:0]        occupancy;
  logic [31:0]                       agu_result;

  agu_sched #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_packet(dispatch_packet),
    .dispatch_ready(dispatch_ready), .cdb(cdb),
    .agu_packet(agu_packet), .occupancy(occupancy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream AGU: registers base+offset of the issued packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) agu_result <= '0;
    else     agu_result <= agu_packet.is_valid
                           ? agu_packet.src_0_a.data + agu_packet.src_0_b.data : '0;
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic              dv;
    instruction_t      pkt;
    writeback_packet_t c0, c1;
    logic              fl;
    int unsigned       e_occ;
    logic              e_rdy, e_iv;
    logic [5:0]        e_dest;
    logic [31:0]       e_sum, e_res;
  } vec_t;
  vec_t vq[$];

  localparam instruction_t      IDLE = '0;
  localparam writeback_packet_t NOWB = '0;

  function automatic operand_t op_rdy(logic [31:0] d);
    return '{is_renamed: 1'b0, tag: '0, data: d};
  endfunction
  function automatic operand_t op_wt(logic [5:0] t);
    return '{is_renamed: 1'b1, tag: t, data: '0};
  endfunction
  function automatic instruction_t mk(operand_t a, operand_t b, logic [5:0] d);
    return '{is_valid: 1'b1, dest_tag: d, src_0_a: a, src_0_b: b};
  endfunction
  function automatic writeback_packet_t wb(logic v, logic [5:0] t, logic [31:0] r);
    return '{is_valid: v, dest_tag: t, result: r};
  endfunction

  task automatic add(logic dv, instruction_t pkt, writeback_packet_t c0, writeback_packet_t c1,
                     logic fl, int unsigned occ, logic rdy, logic iv, logic [5:0] dest,
                     logic [31:0] sum, logic [31:0] res);
    vec_t v;
    v.dv = dv; v.pkt = pkt; v.c0 = c0; v.c1 = c1; v.fl = fl;
    v.e_occ = occ; v.e_rdy = rdy; v.e_iv = iv; v.e_dest = dest; v.e_sum = sum; v.e_res = res;
    vq.push_back(v);
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(logic dv, instruction_t p, writeback_packet_t c0,
                       writeback_packet_t c1, logic fl);
    dispatch_valid  = dv;
    dispatch_packet = p;
    cdb[0]          = c0;
    cdb[1]          = c1;
    flush           = fl;
  endtask

  task automatic chk(string nm, int unsigned occ, logic rdy, logic iv,
                     logic [5:0] dest, logic [31:0] sum);
    cmp({nm, ".occ"}, 32'(occupancy), occ);
    cmp({nm, ".ready"}, 32'(dispatch_ready), 32'(rdy));
    cmp({nm, ".issue"}, 32'(agu_packet.is_valid), 32'(iv));
    if (iv) begin
      cmp({nm, ".dest"}, 32'(agu_packet.dest_tag), 32'(dest));
      cmp({nm, ".sum"}, agu_packet.src_0_a.data + agu_packet.src_0_b.data, sum);
    end else begin
      cmp({nm, ".pkt_nonzero"}, 32'(|agu_packet), 32'd0);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wake a resident entry and follow it through issue and removal.
  task automatic wake_issue(string nm, logic [5:0] tag, logic [31:0] data,
                            int unsigned occ, logic [5:0] dest);
    drive(1'b0, IDLE, wb(1'b1, tag, data), NOWB, 1'b0);
    #1; chk({nm, "_c0"}, occ, 1'b1, BP, dest, data); tick;
    drive(1'b0, IDLE, NOWB, NOWB, 1'b0);
    #1; chk({nm, "_c1"}, BP ? occ - 1 : occ, 1'b1, !BP, dest, data); tick;
    #1; chk({nm, "_c2"}, occ - 1, 1'b1, 1'b0, 6'd0, 32'd0); tick;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, IDLE, NOWB, NOWB, 1'b0);
    #12;
    chk("reset", 0, 1'b1, 1'b0, 6'd0, 32'd0);
    rst = 1'b0;
    tick;

    add(1, mk(op_rdy(32'h1000), op_rdy(32'h10), 6'd5), NOWB, NOWB, 0, 0, 1, 0, 0, 0, 0);
    add(0, IDLE, NOWB, NOWB, 0, 1, 1, 1, 5, 32'h1010, 0);
    add(0, IDLE, NOWB, NOWB, 0, 0, 1, 0, 0, 0, 32'h1010);
    add(1, mk(op_wt(6'd7), op_rdy(32'h4), 6'd1), NOWB, NOWB, 0, 0, 1, 0, 0, 0, 0);
    add(1, mk(op_rdy(32'h2000), op_rdy(32'h8), 6'd2), NOWB, NOWB, 0, 1, 1, 0, 0, 0, 0);
    add(0, IDLE, NOWB, NOWB, 0, 2, 1, 1, 2, 32'h2008, 0);
    add(0, IDLE, NOWB, wb(1, 6'd7, 32'h20), 0, 1, 1, BP, 1, 32'h24, 32'h2008);
    add(0, IDLE, NOWB, NOWB, 0, BP ? 0 : 1, 1, !BP, 1, 32'h24, BP ? 32'h24 : 32'h0);
    add(0, IDLE, NOWB, NOWB, 0, 0, 1, 0, 0, 0, BP ? 32'h0 : 32'h24);
    add(1, mk(op_wt(6'd9), op_rdy(32'h1), 6'd3), wb(1, 6'd9, 32'h300), NOWB, 0, 0, 1, 0, 0, 0, 0);
    add(0, IDLE, NOWB, NOWB, 0, 1, 1, 1, 3, 32'h301, 0);
    add(0, IDLE, NOWB, NOWB, 0, 0, 1, 0, 0, 0, 32'h301);
    add(1, mk(op_rdy(32'h10), op_rdy(32'h20), 6'd4), NOWB, NOWB, 0, 0, 1, 0, 0, 0, 0);
    add(1, mk(op_rdy(32'h1), op_rdy(32'h2), 6'd6), NOWB, NOWB, 0, 1, 1, 1, 4, 32'h30, 0);
    add(0, IDLE, NOWB, NOWB, 0, 1, 1, 1, 6, 32'h3, 32'h30);
    add(0, IDLE, NOWB, NOWB, 0, 0, 1, 0, 0, 0, 32'h3);
    add(1, mk(op_wt(6'd10), op_rdy(32'h0), 6'd7), NOWB, NOWB, 0, 0, 1, 0, 0, 0, 0);
    add(0, IDLE, wb(0, 6'd10, 32'h40), NOWB, 0, 1, 1, 0, 0, 0, 0);
    add(0, IDLE, wb(1, 6'd11, 32'h40), NOWB, 0, 1, 1, 0, 0, 0, 0);
    add(0, IDLE, NOWB, NOWB, 1, 1, 1, 0, 0, 0, 0);
    add(0, IDLE, NOWB, NOWB, 0, 0, 1, 0, 0, 0, 0);

    foreach (vq[k]) begin
      drive(vq[k].dv, vq[k].pkt, vq[k].c0, vq[k].c1, vq[k].fl);
      #1;
      chk($sformatf("row%0d", k), vq[k].e_occ, vq[k].e_rdy, vq[k].e_iv, vq[k].e_dest, vq[k].e_sum);
      cmp($sformatf("row%0d.agu_result", k), agu_result, vq[k].e_res);
      tick;
    end

    // Fill with waiting ops: tags 20..27, dest 10..17.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(1'b1, mk(op_wt(6'(20 + i)), op_rdy(32'h0), 6'(10 + i)), NOWB, NOWB, 1'b0);
      #1; chk($sformatf("fill%0d", i), i, 1'b1, 1'b0, 6'd0, 32'd0); tick;
    end
    drive(1'b1, mk(op_rdy(32'h1), op_rdy(32'h1), 6'd30), wb(1'b1, 6'd23, 32'h500), NOWB, 1'b0);
    #1; chk("full_wake", 8, 1'b0, BP, 6'd13, 32'h500); tick;
    drive(!BP, mk(op_rdy(32'h1), op_rdy(32'h1), 6'd30), NOWB, NOWB, 1'b0);
    #1; chk("full_issue", BP ? 7 : 8, BP, !BP, 6'd13, 32'h500); tick;
    drive(1'b0, IDLE, NOWB, NOWB, 1'b0);
    #1; chk("after_full", 7, 1'b1, 1'b0, 6'd0, 32'd0); tick;
    wake_issue("shift_a", 6'd24, 32'h600, 7, 6'd14);
    wake_issue("shift_b", 6'd27, 32'h700, 6, 6'd17);

    // Five entries left; make entry 0 ready going into the flush cycle.
    drive(1'b0, IDLE, wb(!BP, 6'd20, 32'h800), NOWB, 1'b0);
    #1; chk("pre_flush", 5, 1'b1, 1'b0, 6'd0, 32'd0); tick;
    drive(1'b1, mk(op_rdy(32'h5), op_rdy(32'h6), 6'd9), wb(1'b1, 6'd20, 32'h800), NOWB, 1'b1);
    #1; chk("flush", 5, 1'b1, 1'b0, 6'd0, 32'd0); tick;
    drive(1'b0, IDLE, NOWB, NOWB, 1'b0);
    #1; chk("post_flush", 0, 1'b1, 1'b0, 6'd0, 32'd0); tick;
    #1; chk("flush_drop", 0, 1'b1, 1'b0, 6'd0, 32'd0); tick;

    // Asynchronous reset with three resident entries.
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, mk(op_wt(6'(40 + i)), op_rdy(32'h0), 6'(20 + i)), NOWB, NOWB, 1'b0);
      #1; chk($sformatf("prerst%0d", i), i, 1'b1, 1'b0, 6'd0, 32'd0); tick;
    end
    drive(1'b0, IDLE, wb(1'b1, 6'd40, 32'h900), NOWB, 1'b0);
    #1; chk("rst_before", 3, 1'b1, BP, 6'd20, 32'h900);
    #1; rst = 1'b1;
    #1; chk("rst_async", 0, 1'b1, 1'b0, 6'd0, 32'd0);
    tick; tick;
    rst = 1'b0;
    drive(1'b0, IDLE, wb(1'b1, 6'd40, 32'h900), wb(1'b1, 6'd41, 32'h910), 1'b0);
    #1; chk("rst_release", 0, 1'b1, 1'b0, 6'd0, 32'd0); tick;
    drive(1'b0, IDLE, NOWB, NOWB, 1'b0);
    #1; chk("rst_idle", 0, 1'b1, 1'b0, 6'd0, 32'd0); tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/agu_sched.md
# agu_sched

Issue scheduler for the address-generation unit. It buffers dispatched load/store micro-ops and captures their base/offset operands from the CDB as they become ready. Each cycle it issues the oldest ready entry to the AGU's input register. It sits between rename/dispatch and the AGU, and is the only block that drives the AGU input packet.

## Interface
- DEPTH, 8, number of scheduler entries (power of two not required, ≥2)
- CDB_PORTS, 2, number of writeback broadcast ports snooped for wakeup
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all entries (mispredict/exception)
- dispatch_valid  in  1  dispatch offers a memory micro-op
- dispatch_packet  in  $bits(instruction_t)  micro-op with src_0_a (base), src_0_b (offset), dest_tag
- dispatch_ready  out  1  scheduler can accept this cycle
- cdb  in  CDB_PORTS × $bits(writeback_packet_t)  broadcast results (dest_tag, result, is_valid)
- agu_packet  out  $bits(instruction_t)  packet to AGU; is_valid=1 means issue this cycle
- occupancy  out  $clog2(DEPTH+1)  valid entries, for perf counters

## Operation
- Operand state: operand_t.is_renamed=1 means waiting on operand_t.tag; 0 means data is valid.
- Storage is a collapsing queue: entry 0 is the oldest; valid entries are contiguous from 0.
- Dispatch: the handshake is dispatch_valid && dispatch_ready. The packet is written at the tail, after collapse.
- Wakeup: each cycle every valid entry compares each waiting operand's tag against every cdb port with is_valid=1. On a match it latches result into data and clears is_renamed.
- Dispatch-time wakeup: if a dispatching operand's tag matches a cdb port in the same cycle, the entry is written already ready, with the CDB data.
- Select: the lowest-index entry with both operands ready. At most one issue per cycle. The AGU has no backpressure, so issue is unconditional.
- Issue drives agu_packet with that entry, is_valid=1. The entry is removed and the entries above it shift down by one at the edge.
- No issue: agu_packet is all zeros.
- dispatch_ready = (occupancy < DEPTH), from registered state only. It does not credit a same-cycle issue.
- Simultaneous dispatch+issue: occupancy is unchanged, and the new entry lands at index occupancy-1 after collapse.
- Flush: agu_packet.is_valid is forced to 0 in the flush cycle. All entries are invalidated at the edge. A dispatch in the flush cycle is dropped. occupancy=0 next cycle.
- Reset (async): all entries invalid, occupancy=0, dispatch_ready=1, agu_packet=0.
- dest_tag is passed through unmodified. The scheduler never generates exceptions.

## Timing
- agu_packet is combinational from entry state (plus the CDB in bypass mode). The AGU registers it, so the address appears on agu_result one cycle after issue.
- Dispatch with ready operands at cycle t → issue at t+1 → AGU result at t+2.
- Operand broadcast on cdb at cycle t to a resident entry → issue at t+1 (without bypass) or t (with bypass).
- Full: at occupancy==DEPTH, dispatch_ready=0 even if an issue occurs the same cycle.
- Empty: nothing issues, and a dispatching entry cannot issue in its own dispatch cycle.

## Configuration
- AGU_SCHED_BYPASS_EN defined: select also treats an operand as ready if its tag matches a valid cdb port in the current cycle, and agu_packet carries the forwarded CDB data. Wakeup-to-issue latency is 0 cycles.
- Undefined: select uses registered ready bits only. Wakeup-to-issue latency is 1 cycle, and the cdb-to-agu_packet path is removed.

## Structure
- Shared package (uarch_pkg): AGU_SCHED_DEPTH default constant and the sched_entry_t typedef (valid + instruction_t). instruction_t, operand_t and writeback_packet_t already live there.
- One sub-module: agu_sched_wakeup. It takes one operand_t and the cdb vector and returns the updated operand_t plus a match flag. It is instantiated twice per entry and twice on the dispatch path.
- Oldest-ready select is a priority encoder on the ready vector, kept inline.

## Test plan
- Reset mid-operation with 3 entries → outputs cleared asynchronously, occupancy=0, dispatch_ready=1, no issue after release.
- Dispatch base=0x1000, offset=0x10, both ready, tag 5 at cycle 0 → agu_packet.is_valid=1 with dest_tag 5 at cycle 1; agu_result=0x1010 at cycle 2.
- Dispatch A (waiting on tag 7), then B (ready) → B issues first. cdb tag 7 data 0x20 → A issues 1 cycle later (0 with AGU_SCHED_BYPASS_EN) with data 0x20.
- Fill 8 entries all waiting → dispatch_ready=0. Broadcast a tag that wakes entry 3 → it issues, entries 4–7 shift down, dispatch_ready=1 next cycle.
- Dispatch in the same cycle as a cdb match on its tag → entry is written ready and issues the following cycle.
- flush with 5 entries and a ready entry at index 0 → no issue in the flush cycle, occupancy=0 next cycle, a same-cycle dispatch is dropped.
